// File: rtl/addr8u_pkg.sv
// Shared types and widths for the redundant adder sequencer.
package addr8u_pkg;
    localparam int OP_W  = 8;
    localparam int SUM_W = 9;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/addr8u_redundant_seq_if.sv
// Requester, adder and result signals of the sequencer, bundled as one bus.
interface addr8u_redundant_seq_if #(
    parameter int FAULT_CNT_W = 8
);
    import addr8u_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [OP_W-1:0]        in_a;
    logic [OP_W-1:0]        in_b;
    logic [OP_W-1:0]        add_a;
    logic [OP_W-1:0]        add_b;
    logic [SUM_W-1:0]       add_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic [SUM_W-1:0]       out_sum;
    logic                   out_err;
    logic                   out_uncorr;
    logic [FAULT_CNT_W-1:0] fault_cnt;
    logic                   busy;

    modport slave (
        input  in_valid, in_a, in_b, add_sum, out_ready,
        output in_ready, add_a, add_b, out_valid, out_sum, out_err,
               out_uncorr, fault_cnt, busy
    );

    modport master (
        output in_valid, in_a, in_b, add_sum, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_sum, out_err,
               out_uncorr, fault_cnt, busy
    );
endinterface

// File: rtl/addr8u_vote3.sv
// Combinational 3-way majority over three 9-bit pass results.
module addr8u_vote3
    import addr8u_pkg::*;
(
    input  logic [SUM_W-1:0] i_r0,
    input  logic [SUM_W-1:0] i_r1,
    input  logic [SUM_W-1:0] i_r2,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_err,
    output logic             o_uncorr
);
    always_comb begin
        o_sum    = i_r2;
        o_err    = 1'b1;
        o_uncorr = 1'b1;
        if ((i_r0 == i_r1) && (i_r1 == i_r2)) begin
            o_sum    = i_r0;
            o_err    = 1'b0;
            o_uncorr = 1'b0;
        end else if ((i_r0 == i_r1) || (i_r0 == i_r2)) begin
            o_sum    = i_r0;
            o_uncorr = 1'b0;
        end else if (i_r1 == i_r2) begin
            o_sum    = i_r1;
            o_uncorr = 1'b0;
        end
    end
endmodule

// File: rtl/addr8u_redundant_seq.sv
// Time-redundancy sequencer: runs one operand pair through an external adder
// 2 or 3 times (pass 1 swapped), votes the results and counts faulty outputs.
module addr8u_redundant_seq
    import addr8u_pkg::*;
#(
    parameter int N_PASS      = 3,
    parameter int EARLY_EXIT  = 1,
    parameter int FAULT_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    addr8u_redundant_seq_if.slave   bus
);
    state_t                 r_state, w_next;
    logic [OP_W-1:0]        r_add_a, r_add_b, w_add_a, w_add_b;
    logic [SUM_W-1:0]       r_r0, r_r1, r_r2;
    logic [SUM_W-1:0]       r_out_sum;
    logic                   r_out_err, r_out_uncorr;
    logic [FAULT_CNT_W-1:0] r_fault_cnt;
    logic [SUM_W-1:0]       w_v1, w_v2, w_sum;
    logic                   w_err, w_uncorr;

    // The vote is taken on the edge entering DONE, so the pass in flight is
    // read straight from add_sum; without a third pass r2 is tied to r0.
    assign w_v1 = (r_state == P1) ? bus.add_sum : r_r1;
    assign w_v2 = (r_state == P2) ? bus.add_sum : r_r0;

    addr8u_vote3 u_vote (
        .i_r0     (r_r0),
        .i_r1     (w_v1),
        .i_r2     (w_v2),
        .o_sum    (w_sum),
        .o_err    (w_err),
        .o_uncorr (w_uncorr)
    );

    always_comb begin
        w_next  = r_state;
        w_add_a = r_add_a;
        w_add_b = r_add_b;
        case (r_state)
            IDLE: if (bus.in_valid) begin
                w_next  = P0;
                w_add_a = bus.in_a;
                w_add_b = bus.in_b;
            end
            P0: begin
                w_next  = P1;
                w_add_a = r_add_b;
                w_add_b = r_add_a;
            end
            P1: begin
                if (N_PASS == 2 || (EARLY_EXIT != 0 && bus.add_sum == r_r0)) begin
                    w_next  = DONE;
                    w_add_a = '0;
                    w_add_b = '0;
                end else begin
                    w_next  = P2;
                    w_add_a = r_add_b;
                    w_add_b = r_add_a;
                end
            end
            P2: begin
                w_next  = DONE;
                w_add_a = '0;
                w_add_b = '0;
            end
            DONE: if (bus.out_ready) w_next = IDLE;
            default: begin
                w_next  = IDLE;
                w_add_a = '0;
                w_add_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_r0         <= '0;
            r_r1         <= '0;
            r_r2         <= '0;
            r_out_sum    <= '0;
            r_out_err    <= 1'b0;
            r_out_uncorr <= 1'b0;
            r_fault_cnt  <= '0;
        end else begin
            r_state <= w_next;
            r_add_a <= w_add_a;
            r_add_b <= w_add_b;
            if (r_state == P0) r_r0 <= bus.add_sum;
            if (r_state == P1) r_r1 <= bus.add_sum;
            if (r_state == P2) r_r2 <= bus.add_sum;
            if (w_next == DONE && r_state != DONE) begin
                r_out_sum    <= w_sum;
                r_out_err    <= w_err;
                r_out_uncorr <= (N_PASS == 2) ? w_err : w_uncorr;
            end
            if (r_state == DONE && bus.out_ready && r_out_err && r_fault_cnt != '1)
                r_fault_cnt <= r_fault_cnt + 1'b1;
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.out_valid  = (r_state == DONE);
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
    assign bus.out_sum    = r_out_sum;
    assign bus.out_err    = r_out_err;
    assign bus.out_uncorr = r_out_uncorr;
    assign bus.fault_cnt  = r_fault_cnt;
endmodule

// File: tb/tb_addr8u_redundant_seq.sv
// Scoreboard bench: three sequencer configs, each with a fault-injecting adder model.
module tb_addr8u_redundant_seq;
    localparam int NP[3] = '{3, 3, 2};
    localparam int FW[3] = '{8, 2, 8};

    typedef struct {
        int         d;
        logic [8:0] sum;
        logic       err;
        logic       unc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid[3];
    logic [7:0] in_a[3], in_b[3];
    logic       out_ready[3];
    logic       in_ready[3], out_valid[3], out_err[3], out_uncorr[3], busy[3];
    logic [7:0] add_a[3], add_b[3], fc[3];
    logic [8:0] out_sum[3];
    logic [8:0] fmask[3][4];

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        int pidx = 3;
        addr8u_redundant_seq_if #(.FAULT_CNT_W(FW[g])) ifc ();

        addr8u_redundant_seq #(
            .N_PASS(NP[g]), .EARLY_EXIT(1), .FAULT_CNT_W(FW[g])
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );

        // Pass index counts cycles since accept; index 3 means no injection.
        always @(posedge clk) begin
            if (in_valid[g] && in_ready[g]) pidx <= 0;
            else if (pidx < 3)              pidx <= pidx + 1;
        end

        assign ifc.add_sum   = ({1'b0, ifc.add_a} + {1'b0, ifc.add_b}) ^ fmask[g][pidx];
        assign ifc.in_valid  = in_valid[g];
        assign ifc.in_a      = in_a[g];
        assign ifc.in_b      = in_b[g];
        assign ifc.out_ready = out_ready[g];
        assign in_ready[g]   = ifc.in_ready;
        assign out_valid[g]  = ifc.out_valid;
        assign out_sum[g]    = ifc.out_sum;
        assign out_err[g]    = ifc.out_err;
        assign out_uncorr[g] = ifc.out_uncorr;
        assign busy[g]       = ifc.busy;
        assign add_a[g]      = ifc.add_a;
        assign add_b[g]      = ifc.add_b;
        assign fc[g]         = 8'(ifc.fault_cnt);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output handshake pops one expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst && out_valid[d] && out_ready[d]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_dut", 32'(d), 32'(e.d));
                    chk("sb_sum", 32'(out_sum[d]), 32'(e.sum));
                    chk("sb_err", 32'(out_err[d]), 32'(e.err));
                    chk("sb_uncorr", 32'(out_uncorr[d]), 32'(e.unc));
                end
            end
        end
    end

    // Latency counts edges from the accept edge (1) until out_valid is seen.
    task automatic start_op(input int d, input logic [7:0] a, input logic [7:0] b,
                            input logic [8:0] s, input logic err, input logic unc,
                            input int exp_lat,
                            output logic [7:0] a1, output logic [7:0] b1,
                            output logic [7:0] a2, output logic [7:0] b2);
        int  lat = 0;
        bit  got = 0;
        exp_t e;
        e.d = d; e.sum = s; e.err = err; e.unc = unc;
        sbq.push_back(e);
        a1 = 0; b1 = 0; a2 = 0; b2 = 0;
        in_a[d] = a; in_b[d] = b; in_valid[d] = 1'b1;
        while (lat < 10 && !got) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin in_valid[d] = 1'b0; a1 = add_a[d]; b1 = add_b[d]; end
            if (lat == 2) begin a2 = add_a[d]; b2 = add_b[d]; end
            got = out_valid[d];
        end
        if (!got) chk("timeout", 32'(lat), 32'(exp_lat));
        else      chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] s, input logic err, input logic unc,
                          input int exp_lat);
        logic [7:0] a1, b1, a2, b2;
        start_op(d, a, b, s, err, unc, exp_lat, a1, b1, a2, b2);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] a1, b1, a2, b2;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 0; in_a[d] = 0; in_b[d] = 0; out_ready[d] = 1;
            for (int p = 0; p < 4; p++) fmask[d][p] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid[0]), 0);
        chk("rst_in_ready", 32'(in_ready[0]), 1);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_fault_cnt", 32'(fc[0]), 0);
        chk("rst_add_a", 32'(add_a[0]), 0);
        chk("rst_out_sum", 32'(out_sum[0]), 0);

        // Fault-free carry-out case, early exit.
        start_op(0, 8'hFF, 8'h01, 9'h100, 0, 0, 3, a1, b1, a2, b2);
        chk("p0_add_a", 32'(a1), 32'h FF);
        chk("p0_add_b", 32'(b1), 32'h01);
        chk("p1_add_a", 32'(a2), 32'h01);
        chk("p1_add_b", 32'(b2), 32'hFF);
        @(posedge clk); #1;
        chk("idle_after_hs", 32'(in_ready[0]), 1);
        chk("idle_add_a", 32'(add_a[0]), 0);

        // Pass 1 corrupted: corrected by majority.
        fmask[0][1] = 9'h001;
        run_op(0, 8'h35, 8'h4A, 9'h07F, 1, 0, 4);
        chk("fault_cnt_1", 32'(fc[0]), 1);

        // Every pass differs: uncorrectable, sum from pass 2.
        fmask[0][2] = 9'h002;
        run_op(0, 8'h35, 8'h4A, 9'h07D, 1, 1, 4);
        chk("fault_cnt_2", 32'(fc[0]), 2);
        fmask[0][1] = '0; fmask[0][2] = '0;

        // Backpressure: result held, new requests ignored.
        out_ready[0] = 1'b0;
        start_op(0, 8'h12, 8'h34, 9'h046, 0, 0, 3, a1, b1, a2, b2);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = i[0]; in_a[0] = 8'hAA; in_b[0] = 8'h55;
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid[0]), 1);
            chk("bp_out_sum", 32'(out_sum[0]), 32'h046);
            chk("bp_in_ready", 32'(in_ready[0]), 0);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", 32'(in_ready[0]), 1);
        chk("bp_release_valid", 32'(out_valid[0]), 0);

        // Reset during P1 aborts the operation and clears the counter.
        in_a[0] = 8'h11; in_b[0] = 8'h22; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("p0_busy", 32'(busy[0]), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready[0]), 1);
        chk("mid_rst_out_valid", 32'(out_valid[0]), 0);
        chk("mid_rst_fault_cnt", 32'(fc[0]), 0);
        chk("mid_rst_add_a", 32'(add_a[0]), 0);
        chk("mid_rst_add_b", 32'(add_b[0]), 0);

        // 2-bit counter saturates at 3.
        fmask[1][1] = 9'h001;
        for (int i = 1; i <= 5; i++) begin
            run_op(1, 8'h35, 8'h4A, 9'h07F, 1, 0, 4);
            chk("sat_cnt", 32'(fc[1]), 32'((i > 3) ? 3 : i));
        end

        // Two-pass detect-only config.
        run_op(2, 8'h10, 8'h20, 9'h030, 0, 0, 3);
        fmask[2][1] = 9'h001;
        run_op(2, 8'h35, 8'h4A, 9'h07F, 1, 1, 3);
        chk("np2_fault_cnt", 32'(fc[2]), 1);

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/addr8u_redundant_seq.md
Name: addr8u_redundant_seq

Overview:
Time-redundancy sequencer for the shared combinational 8-bit unsigned fault-resilient adder. It accepts one operand pair, drives it through the adder over 2 or 3 passes (pass 1 uses swapped operands), and compares or majority-votes the 9-bit results. It then returns the sum with error flags and keeps a saturating fault counter. It sits between a requester (valid/ready) and the adder instance, which is attached through the add_* ports.

Parameters:
N_PASS, 3, number of adder passes; legal values 2 (detect only) and 3 (detect and correct)
EARLY_EXIT, 1, N_PASS=3 only: skip pass 2 when pass 0 and pass 1 results agree
FAULT_CNT_W, 8, width of the saturating fault counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  high only in IDLE
in_a  in  8  operand A
in_b  in  8  operand B
add_a  out  8  adder operand A (registered)
add_b  out  8  adder operand B (registered)
add_sum  in  9  adder result O[8:0], combinational from add_a/add_b
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  9  voted sum
out_err  out  1  at least one pass disagreed
out_uncorr  out  1  no majority (N_PASS=3), or any mismatch (N_PASS=2)
fault_cnt  out  FAULT_CNT_W  count of results delivered with out_err=1, saturating
busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, add_a=add_b=0, out_valid=0, out_sum=0, out_err=0, out_uncorr=0, fault_cnt=0, busy=0, r0/r1/r2=0.
- States: IDLE, P0, P1, P2, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge T, latch A and B, set add_a=A, add_b=B, go to P0.
- P0 (cycle T+1): capture add_sum into r0 at the end of the cycle. Set add_a=B, add_b=A. Go to P1.
- P1: capture r1. Next state:
  - N_PASS=2: DONE.
  - N_PASS=3, EARLY_EXIT=1 and add_sum==r0: DONE.
  - Otherwise: P2, with add_a=A, add_b=B.
- P2: capture r2, go to DONE.
- add_a/add_b return to 0 on entry to DONE/IDLE.
- DONE: out_valid=1, and out_sum/out_err/out_uncorr are registered on entry. On out_valid&&out_ready, go to IDLE. Outputs stay stable while out_ready=0. No new operand is accepted until the handshake completes, so there is no pipelining.
- Latency, accept edge to out_valid high:
  - 3 cycles: N_PASS=2, or early exit taken.
  - 4 cycles: full 3-pass run.
- Vote, N_PASS=3:
  - r0==r1==r2, or early exit taken: sum=r0, err=0.
  - Exactly two agree: sum=majority value, err=1, uncorr=0.
  - All three differ: sum=r2, err=1, uncorr=1.
- Vote, N_PASS=2: sum=r0, err=uncorr=(r0!=r1).
- fault_cnt: +1 on each output handshake with out_err=1; holds at all-ones.
- Arithmetic is done only in the external adder; the block holds no adder logic. Comparisons are full 9-bit equality.
- Reset mid-operation (any state) returns to IDLE on the next edge. In-flight data is discarded, out_valid drops, and fault_cnt clears.
- in_valid arriving while busy is ignored; the requester must hold it.

Decomposition:
- Shared package addr8u_pkg: state enum (IDLE/P0/P1/P2/DONE), SUM_W=9, OP_W=8.
- One natural sub-module: addr8u_vote3 (combinational 3-way 9-bit majority returning sum/err/uncorr), reused for N_PASS=2 by tying r2=r0.

Test Plan:
- Fault-free, default params, A=8'hFF, B=8'h01 -> out_sum=9'h100, err=0, uncorr=0, out_valid 3 cycles after accept (early exit), add_a/add_b seen as FF/01 then 01/FF.
- Adder model flips bit0 in pass 1 only, A=8'h35, B=8'h4A -> passes 07F/07E/07F, out_sum=9'h07F, err=1, uncorr=0, latency 4, fault_cnt=1.
- Model corrupts every pass differently (07F, 07E, 07D) -> out_sum=9'h07D, err=1, uncorr=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_sum/flags stable, in_ready=0, in_valid pulses ignored; handshake then returns to IDLE next edge.
- rst asserted during P1 -> next cycle state IDLE, out_valid=0, in_ready=1, fault_cnt=0, add_a=add_b=0.
- FAULT_CNT_W=2, five consecutive erroneous results -> fault_cnt saturates at 2'b11. N_PASS=2 with mismatch -> err=uncorr=1, latency 3.
